// File: rtl/param_sequence_detector_moore_pkg.sv
// Shared definitions for the programmable Moore sequence detector.
// The state is the count of matched pattern bits; DETECT is the state equal to the latched length.
package param_sequence_detector_moore_pkg;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;

    // Width needed to hold a length or state value in the range 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/param_sequence_detector_moore_seq_next_state.sv
// Combinational KMP-style next-state search: longest pattern prefix that is a suffix
// of the matched history extended by the incoming bit.
module seq_next_state
    import param_sequence_detector_moore_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    localparam int unsigned LEN_W  = len_width(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   state_i,
    input  logic               bit_i,
    input  logic               overlap_i,
    output logic [LEN_W-1:0]   next_o
);

    logic [MAX_LEN:0] recent;
    logic             ok;
    int unsigned      kk;
    int unsigned      ll;
    int unsigned      jmax;

    always_comb begin
        next_o = '0;
        ok     = 1'b0;
        kk     = int'(state_i);
        ll     = int'(len_i);
        // recent[t] is the t-th most recent history bit; the matched history equals pattern[0..k-1]
        recent    = '0;
        recent[0] = bit_i;
        for (int unsigned m = 0; m < MAX_LEN; m++) begin
            for (int unsigned t = 1; t <= MAX_LEN; t++) begin
                if (m + t == kk) begin
                    recent[t] = pattern_i[m];
                end
            end
        end
        jmax = (kk + 1 < ll) ? kk + 1 : ll;
        for (int unsigned j = 1; j <= MAX_LEN; j++) begin
            if (j <= jmax) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < j; i++) begin
                    if (pattern_i[i] != recent[j-1-i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    next_o = LEN_W'(j);
                end
            end
        end
        // Non-overlapping mode drops all history on leaving DETECT.
        if (kk == ll && !overlap_i) begin
            next_o = (bit_i == pattern_i[0]) ? LEN_W'(1) : '0;
        end
    end

endmodule

// File: rtl/param_sequence_detector_moore.sv
// Programmable Moore serial pattern detector with valid qualifier, run-time config
// and a saturating match counter; detector_out is registered and input-independent.
module param_sequence_detector_moore
    import param_sequence_detector_moore_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned LEN_W  = len_width(MAX_LEN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               valid_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pattern_len,
    input  logic               overlap_en,
    input  logic               clear_count,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [LEN_W-1:0]   state_q, state_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [LEN_W-1:0]   state_nxt;
    logic [LEN_W-1:0]   len_clamped;
    logic               enter_detect;

    seq_next_state #(
        .MAX_LEN(MAX_LEN)
    ) u_next (
        .pattern_i(pattern_q),
        .len_i    (len_q),
        .state_i  (state_q),
        .bit_i    (sequence_in),
        .overlap_i(overlap_q),
        .next_o   (state_nxt)
    );

    always_comb begin
        len_clamped  = (pattern_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pattern_len;
        pattern_d    = pattern_q;
        len_d        = len_q;
        overlap_d    = overlap_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        enter_detect = 1'b0;

        if (cfg_load) begin
            pattern_d = pattern;
            len_d     = len_clamped;
            overlap_d = overlap_en;
            state_d   = '0;
        end else if (valid_in && len_q != '0) begin
            state_d      = state_nxt;
            enter_detect = (state_nxt == len_q);
        end

        if (clear_count) begin
            cnt_d = '0;
        end else if (enter_detect && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Output and saturation flag are decoded from next-state values so they register glitch-free.
        det_d = (len_d != '0) && (state_d == len_d);
        sat_d = (cnt_d == '1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            state_q   <= '0;
            det_q     <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            state_q   <= state_d;
            det_q     <= det_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign detector_out = det_q;
    assign match_count  = cnt_q;
    assign count_sat    = sat_q;

endmodule

// File: tb/tb_param_sequence_detector_moore.sv
// Directed self-checking bench for param_sequence_detector_moore (default and 2-bit counter builds).
module tb_param_sequence_detector_moore;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sequence_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pattern_len = '0;
    logic       overlap_en = 1'b0;
    logic       clear_count = 1'b0;

    logic       det_a;
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       det_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    param_sequence_detector_moore #(
        .MAX_LEN(8),
        .CNT_W  (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .valid_in    (valid_in),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .pattern_len (pattern_len),
        .overlap_en  (overlap_en),
        .clear_count (clear_count),
        .detector_out(det_a),
        .match_count (cnt_a),
        .count_sat   (sat_a)
    );

    param_sequence_detector_moore #(
        .MAX_LEN(8),
        .CNT_W  (2)
    ) dut_small (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .valid_in    (valid_in),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .pattern_len (pattern_len),
        .overlap_en  (overlap_en),
        .clear_count (clear_count),
        .detector_out(det_b),
        .match_count (cnt_b),
        .count_sat   (sat_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        pattern     = p;
        pattern_len = l;
        overlap_en  = o;
        cfg_load    = 1'b1;
        valid_in    = 1'b0;
        tick();
        cfg_load = 1'b0;
        check("load_det", det_a, 0);
    endtask

    task automatic clr();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_det, input string tag);
        sequence_in = b;
        valid_in    = 1'b1;
        tick();
        valid_in = 1'b0;
        check(tag, det_a, exp_det);
    endtask

    // bits[i] is sent i-th; expd[i] is detector_out after that edge.
    task automatic stream(input logic [7:0] bits, input logic [7:0] expd, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            send(bits[i], expd[i], $sformatf("%s_bit%0d", tag, i + 1));
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check("rst_det", det_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_sat", sat_a, 0);
        reset = 1'b1;
        tick();

        // Disabled at reset (len 0)
        send(1'b1, 1'b0, "rst_disabled");

        // 1: 1011, overlap
        load(8'h0D, 4'd4, 1'b1);
        clr();
        stream(8'b0110_1101, 8'b0100_1000, 7, "t1");
        check("t1_cnt", cnt_a, 2);

        // 2: same stream, no overlap
        load(8'h0D, 4'd4, 1'b0);
        clr();
        stream(8'b0110_1101, 8'b0000_1000, 7, "t2");
        check("t2_cnt", cnt_a, 1);

        // 3: 111 overlap and non-overlap
        load(8'h07, 4'd3, 1'b1);
        clr();
        stream(8'b0001_1111, 8'b0001_1100, 5, "t3o");
        check("t3o_cnt", cnt_a, 3);
        load(8'h07, 4'd3, 1'b0);
        clr();
        stream(8'b0001_1111, 8'b0000_0100, 5, "t3n");
        check("t3n_cnt", cnt_a, 1);

        // 4: reset mid-pattern
        load(8'h0D, 4'd4, 1'b1);
        stream(8'b0000_0101, 8'b0000_0000, 3, "t4");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t4_rst_cnt", cnt_a, 0);
        send(1'b1, 1'b0, "t4_after");
        load(8'h0D, 4'd4, 1'b1);
        stream(8'b0000_1101, 8'b0000_1000, 4, "t4_reload");
        check("t4_cnt", cnt_a, 1);

        // 5: valid_in low mid-pattern
        load(8'h0D, 4'd4, 1'b1);
        clr();
        stream(8'b0000_0001, 8'b0000_0000, 2, "t5a");
        for (int i = 0; i < 3; i++) begin
            sequence_in = (i != 2);
            valid_in    = 1'b0;
            tick();
            check($sformatf("t5_hold%0d", i), det_a, 0);
        end
        stream(8'b0000_0011, 8'b0000_0010, 2, "t5b");
        valid_in    = 1'b0;
        sequence_in = 1'b0;
        tick();
        check("t5_det_hold", det_a, 1);
        check("t5_cnt", cnt_a, 1);

        // Length clamp: 15 -> 8
        load(8'hFF, 4'd15, 1'b0);
        clr();
        stream(8'hFF, 8'b1000_0000, 8, "clamp");

        // cfg_load ignores the bit on its edge
        pattern     = 8'h01;
        pattern_len = 4'd1;
        overlap_en  = 1'b1;
        cfg_load    = 1'b1;
        valid_in    = 1'b1;
        sequence_in = 1'b1;
        tick();
        cfg_load = 1'b0;
        valid_in = 1'b0;
        check("cfg_ign_det", det_a, 0);
        check("cfg_ign_cnt", cnt_a, 1);
        clr();

        // 6: saturation on the 2-bit build, then clear beats increment
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1, $sformatf("t6_det%0d", i + 1));
            check($sformatf("t6_cntb%0d", i + 1), cnt_b, (i < 3) ? i + 1 : 3);
        end
        check("t6_satb", sat_b, 1);
        check("t6_cnta", cnt_a, 5);
        check("t6_sata", sat_a, 0);
        clear_count = 1'b1;
        valid_in    = 1'b1;
        sequence_in = 1'b1;
        tick();
        clear_count = 1'b0;
        valid_in    = 1'b0;
        check("t6_clr_cntb", cnt_b, 0);
        check("t6_clr_satb", sat_b, 0);
        check("t6_clr_cnta", cnt_a, 0);
        check("t6_clr_det", det_a, 1);

        // L==0 disables detection; cfg_load keeps the count
        send(1'b1, 1'b1, "l0_pre");
        load(8'h01, 4'd0, 1'b1);
        check("l0_cnt_kept", cnt_a, 1);
        stream(8'b0000_0111, 8'b0000_0000, 3, "l0");
        check("l0_cnt", cnt_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
